// File: rtl/hit_histogrammer.sv
// Eight-channel rising-edge hit counter bank: synchronised inputs, per-channel
// holdoff, 32-bit saturating counts with sticky overflow, collision-safe clear.
module hit_histogrammer #(
  parameter int NCH     = 8,
  parameter int HOLDOFF = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       hits,
  input  logic                 enable,
  input  logic                 resethist,
  output logic [NCH-1:0][31:0] h,
  output logic [NCH-1:0]       ovf
);

  localparam int HOW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HOW-1:0] HO_LOAD = HOW'(HOLDOFF);

  logic [NCH-1:0]           s1_q, s1_d;
  logic [NCH-1:0]           s2_q, s2_d;
  logic [NCH-1:0]           s3_q, s3_d;
  logic [NCH-1:0][HOW-1:0]  ho_q, ho_d;
  logic [NCH-1:0][31:0]     h_q, h_d;
  logic [NCH-1:0]           ovf_q, ovf_d;
  logic [NCH-1:0]           rise;
  logic [NCH-1:0]           accepted;
  logic [NCH-1:0]           count_ev;

  always_comb begin
    s1_d     = hits;
    s2_d     = s1_q;
    s3_d     = s2_q;
    rise     = s2_q & ~s3_q;
    accepted = '0;
    count_ev = '0;
    ho_d     = ho_q;
    h_d      = h_q;
    ovf_d    = ovf_q;
    for (int i = 0; i < NCH; i++) begin
      accepted[i] = rise[i] && (ho_q[i] == '0);
      count_ev[i] = accepted[i] && enable;

      // Holdoff runs even while counting is disabled.
      if (accepted[i]) begin
        ho_d[i] = HO_LOAD;
      end else if (ho_q[i] != '0) begin
        ho_d[i] = ho_q[i] - HOW'(1);
      end

      // A clear that coincides with a counted edge keeps that edge.
      if (resethist) begin
        h_d[i]   = count_ev[i] ? 32'd1 : 32'd0;
        ovf_d[i] = 1'b0;
      end else if (count_ev[i]) begin
        if (h_q[i] == 32'hFFFF_FFFF) begin
          ovf_d[i] = 1'b1;
        end else begin
          h_d[i] = h_q[i] + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      ho_q  <= '0;
      h_q   <= '0;
      ovf_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      ho_q  <= ho_d;
      h_q   <= h_d;
      ovf_q <= ovf_d;
    end
  end

  assign h   = h_q;
  assign ovf = ovf_q;

endmodule
